// File: rtl/pwm_basico.sv
// rtl/pwm_basico.sv - PWM generator with prescaler and triangle duty sweep
// Duty (ciclo) steps once per period, so each period has one constant duty.
module pwm_basico #(
    parameter int R = 8,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    output logic         pwm_out,
    output logic [R-1:0] ciclo
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(N - 1);
    localparam logic [R-1:0] ONE = R'(1);
    localparam logic [R-1:0] CNT_MAX = {R{1'b1}};
    localparam logic [R-1:0] CNT_MAX_M1 = {{(R-1){1'b1}}, 1'b0};

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    logic [PW-1:0] presc;
    logic [R-1:0]  cnt;
    logic [R-1:0]  cnt_next;
    logic [R-1:0]  ciclo_next;
    logic          tick;
    logic          wrap;
    dir_t          dir;
    dir_t          dir_next;

    assign tick     = (presc == PRE_LAST);
    assign wrap     = tick && (cnt == CNT_MAX);
    assign cnt_next = cnt + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // pwm_out uses the post-edge counter and duty so it is aligned with counter value 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else if (tick) begin
            cnt     <= cnt_next;
            pwm_out <= (cnt_next < ciclo_next);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir   <= DIR_UP;
            ciclo <= '0;
        end else begin
            dir   <= dir_next;
            ciclo <= ciclo_next;
        end
    end

    // Direction flips in the same update that lands on an endpoint, so no value repeats
    always_comb begin
        dir_next = dir;
        if (wrap) begin
            if (dir == DIR_UP && ciclo == CNT_MAX_M1) begin
                dir_next = DIR_DOWN;
            end else if (dir == DIR_DOWN && ciclo == ONE) begin
                dir_next = DIR_UP;
            end
        end
    end

    always_comb begin
        ciclo_next = ciclo;
        if (wrap) begin
            if (dir == DIR_UP) begin
                ciclo_next = ciclo + ONE;
            end else begin
                ciclo_next = ciclo - ONE;
            end
        end
    end

endmodule

// File: tb/tb_pwm_basico.sv
// tb/tb_pwm_basico.sv - directed bench for pwm_basico (R=6, N=1 and N=4)
module tb_pwm_basico;

    logic       clk = 1'b0;
    logic       reset1 = 1'b1;
    logic       reset4 = 1'b1;
    logic       pwm1;
    logic       pwm4;
    logic [5:0] ciclo1;
    logic [5:0] ciclo4;
    int         n_checks = 0;
    int         n_fail = 0;

    pwm_basico #(.R(6), .N(1)) dut1 (.clk(clk), .reset(reset1), .pwm_out(pwm1), .ciclo(ciclo1));
    pwm_basico #(.R(6), .N(4)) dut4 (.clk(clk), .reset(reset4), .pwm_out(pwm4), .ciclo(ciclo4));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tri_duty(input int p);
        int m;
        m = p % 126;
        return (m <= 63) ? m : 126 - m;
    endfunction

    // Samples one 64-clock period of dut1, starting at the current negedge
    task automatic run_period(input int p, output int c_obs);
        int  exp_c;
        int  hi;
        bit  pat_ok;
        bit  stable;
        bit  x_seen;
        exp_c  = tri_duty(p);
        hi     = 0;
        pat_ok = 1'b1;
        stable = 1'b1;
        x_seen = 1'b0;
        c_obs  = int'(ciclo1);
        for (int i = 0; i < 64; i++) begin
            if ($isunknown({pwm1, ciclo1})) x_seen = 1'b1;
            if (pwm1 !== (i < exp_c)) pat_ok = 1'b0;
            if (pwm1 === 1'b1) hi++;
            if (int'(ciclo1) != c_obs) stable = 1'b0;
            @(negedge clk);
        end
        check($sformatf("p%0d ciclo", p), c_obs, exp_c);
        check($sformatf("p%0d high_time", p), hi, exp_c);
        check($sformatf("p%0d pattern", p), int'(pat_ok), 1);
        check($sformatf("p%0d ciclo_stable", p), int'(stable), 1);
        check($sformatf("p%0d no_x", p), int'(x_seen), 0);
    endtask

    initial begin
        int c_prev;
        int c_now;
        int idx [1:4];
        int hi3;
        int first3;
        int last3;

        repeat (2) @(negedge clk);
        check("reset pwm1", int'(pwm1), 0);
        check("reset ciclo1", int'(ciclo1), 0);
        check("reset pwm4", int'(pwm4), 0);
        check("reset ciclo4", int'(ciclo4), 0);
        check("reset no_x", int'($isunknown({pwm1, ciclo1, pwm4, ciclo4})), 0);

        // First periods, turnaround and long run: 288 periods of 64 clocks
        reset1 = 1'b0;
        c_prev = 0;
        for (int p = 0; p < 288; p++) begin
            run_period(p, c_now);
            if (p > 0) begin
                check($sformatf("p%0d step", p), (c_now > c_prev) ? c_now - c_prev : c_prev - c_now, 1);
            end
            c_prev = c_now;
        end

        // Async reset mid-period while high with ciclo = 20
        reset1 = 1'b1;
        @(negedge clk);
        reset1 = 1'b0;
        for (int p = 0; p < 20; p++) run_period(p, c_now);
        repeat (5) @(negedge clk);
        check("pre_reset pwm", int'(pwm1), 1);
        check("pre_reset ciclo", int'(ciclo1), 20);
        #2 reset1 = 1'b1;
        #1;
        check("async pwm", int'(pwm1), 0);
        check("async ciclo", int'(ciclo1), 0);
        repeat (2) @(negedge clk);
        reset1 = 1'b0;
        for (int p = 0; p < 4; p++) run_period(p, c_now);

        // Prescale: N=4 gives 256-clock periods, 12 high clocks at ciclo = 3
        reset4 = 1'b0;
        for (int k = 1; k <= 4; k++) idx[k] = -1;
        hi3 = 0;
        first3 = -1;
        last3 = -1;
        for (int i = 0; i < 1280; i++) begin
            for (int k = 1; k <= 4; k++) begin
                if (idx[k] < 0 && int'(ciclo4) == k) idx[k] = i;
            end
            if (int'(ciclo4) == 3 && pwm4 === 1'b1) begin
                hi3++;
                if (first3 < 0) first3 = i;
                last3 = i;
            end
            @(negedge clk);
        end
        check("n4 first_tick_period", idx[1], 256);
        check("n4 period2", idx[2] - idx[1], 256);
        check("n4 period3", idx[3] - idx[2], 256);
        check("n4 period4", idx[4] - idx[3], 256);
        check("n4 high_c3", hi3, 12);
        check("n4 high_start", first3, 768);
        check("n4 high_contig", last3 - first3 + 1, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_basico.md
PWM_BASICO -- requirements
Module: pwm_basico

Interface
REQ-001 The block SHALL expose parameter R, default 8, giving the counter and duty resolution in bits (R >= 2).
REQ-002 The block SHALL expose parameter N, default 1, giving the prescale factor in clock cycles per counter tick (N >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port pwm_out, output, 1 bit: the PWM waveform, registered.
REQ-006 The block SHALL have port ciclo, output, R bits: the current duty value, unsigned, registered.

Function
REQ-007 The prescaler SHALL count 0..N-1 and assert an internal tick when it reaches N-1, then wrap to 0; with N=1 the tick is asserted every clock.
REQ-008 The period counter SHALL be R bits, SHALL increment by 1 on each tick, and SHALL hold otherwise; it wraps from 2^R-1 to 0.
REQ-009 A PWM period SHALL be exactly 2^R ticks, which is 2^R*N clocks.
REQ-010 pwm_out SHALL be registered as (next counter value < ciclo), so that within a period it is high for exactly ciclo ticks, starting at counter value 0.
REQ-011 When ciclo = 0, pwm_out SHALL stay low for the whole period; the maximum duty is (2^R-1)/2^R, and there is no 100 % state.
REQ-012 ciclo SHALL update only on the tick on which the counter wraps from 2^R-1 to 0, so that every period uses one constant duty.
REQ-013 ciclo SHALL follow a triangle sweep driven by an internal direction flag (up/down).
- Up: ciclo increments by 1 each period.
- On reaching 2^R-1 the direction becomes down.
- Down: ciclo decrements by 1 each period.
- On reaching 0 the direction becomes up.
REQ-014 Turnaround SHALL use no repeated value: the sequence for R=2 is 0,1,2,3,2,1,0,1,...
REQ-015 The full sweep SHALL repeat every 2*(2^R-1) periods.
REQ-016 Arithmetic on ciclo SHALL never overflow or underflow; the direction change SHALL occur in the same update that produces the endpoint value.
REQ-017 The design SHALL have no other inputs and SHALL run autonomously after reset.

Reset
REQ-018 While reset = 1, asynchronously and regardless of clk:
- prescaler = 0
- counter = 0
- ciclo = 0
- direction = up
- pwm_out = 0
REQ-019 After reset deassertion, the first rising clk edge SHALL count as prescaler step 0, and the first period SHALL use ciclo = 0.
REQ-020 Reset asserted mid-period or mid-sweep SHALL abort immediately; the sequence SHALL restart from the REQ-018 state, with no partial period retained.
REQ-021 All outputs SHALL be defined (not X) from the first reset assertion onward.

Verification
REQ-022 Scenario "first periods" (R=6, N=1, reset pulse then release):
- First 64 clocks: pwm_out = 0 and ciclo = 0.
- Next 64 clocks: ciclo = 1, pwm_out high for 1 clock then low for 63.
- Third period: ciclo = 2, pwm_out high for 2 clocks.
REQ-023 Scenario "prescale" (R=6, N=4): the period measures 256 clocks; in the period with ciclo = 3, pwm_out is high for 12 consecutive clocks.
REQ-024 Scenario "turnaround" (R=6, N=1):
- Run to the period with ciclo = 63: high for 63 clocks, low for 1.
- Next period: ciclo = 62.
- After 126 periods from reset: ciclo is back to 0 and the direction is up.
REQ-025 Scenario "async reset mid-operation": assert reset between clock edges while pwm_out = 1 and ciclo = 20; pwm_out and ciclo go to 0 before the next clk edge, and after release the REQ-022 sequence repeats exactly.
REQ-026 Scenario "long run" (R=6, N=1, 2^9*36 clocks): check every period length = 64 clocks, high time = ciclo, successive ciclo values differ by exactly 1, and pwm_out is never X.
